// File: rtl/core_pkg.sv
// core_pkg -- shared definitions for the core_sequencer slice.
//   XLEN_DEF / NREG_DEF : default data width and architectural register count
//   ST_*                : sequencer state encodings
//   HALT_INSN           : "jal x0,0" encoding, the conventional self-loop halt
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;
  localparam logic [2:0] ST_WRITE   = 3'd5;
  localparam logic [2:0] ST_HALT    = 3'd6;

  localparam logic [31:0] HALT_INSN = 32'h0000_006F;

endpackage

// File: rtl/core_regfile.sv
// core_regfile -- NREG x XLEN architectural register file.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_rs1_idx / o_rs1_val   : read port 1 (combinational)
//   i_rs2_idx / o_rs2_val   : read port 2 (combinational)
//   i_we, i_rd_idx, i_wdata : write port, applied on the rising edge
//   o_result                : continuous view of register RESULT_REG
// x0 always reads zero and ignores writes; indices >= NREG read zero and
// are never written. Reset clears every register except x2 (SP_INIT).
module core_regfile
  import core_pkg::*;
#(
  parameter int          XLEN       = XLEN_DEF,
  parameter int          NREG       = NREG_DEF,
  parameter int unsigned SP_INIT    = 500,
  parameter int unsigned RESULT_REG = 14,
  localparam int         RW         = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [RW-1:0]   i_rs1_idx,
  input  logic [RW-1:0]   i_rs2_idx,
  input  logic            i_we,
  input  logic [RW-1:0]   i_rd_idx,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rs1_val,
  output logic [XLEN-1:0] o_rs2_val,
  output logic [XLEN-1:0] o_result
);

  localparam logic [RW:0]   NREG_W  = (RW+1)'(NREG);
  localparam logic [RW-1:0] RES_IDX = RW'(RESULT_REG);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_rs1_ok;
  logic            w_rs2_ok;
  logic            w_wr_ok;

  // An index is usable only if it is nonzero and inside the implemented range.
  assign w_rs1_ok = (i_rs1_idx != '0) && ({1'b0, i_rs1_idx} < NREG_W);
  assign w_rs2_ok = (i_rs2_idx != '0) && ({1'b0, i_rs2_idx} < NREG_W);
  assign w_wr_ok  = i_we && (i_rd_idx != '0) && ({1'b0, i_rd_idx} < NREG_W);

  assign o_rs1_val = w_rs1_ok ? r_regs[i_rs1_idx] : '0;
  assign o_rs2_val = w_rs2_ok ? r_regs[i_rs2_idx] : '0;
  assign o_result  = r_regs[RES_IDX];

  // Register storage: reset image, then single write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == 2) ? XLEN'(SP_INIT) : '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_rd_idx] <= i_wdata;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer -- multicycle FETCH/DECODE/EXECUTE/MEM/WRITE sequencer.
// Owns the PC and register file; talks to instruction and data memories via
// REQ/ACK handshakes and to an external combinational decoder and executer.
//   CLK, RST                 : clock, synchronous active-high reset
//   IMEM_REQ/ADDR/ACK/RDATA  : instruction fetch handshake
//   INSTRUCTION              : latched instruction word for the decoder
//   DEC_*                    : decoder register indices and flags
//   RS1_VAL, RS2_VAL, PC_OUT : operands and PC for the executer
//   EXE_RESULT, EXE_NEXT_PC  : executer result / memory address, next PC
//   DMEM_REQ/WE/ADDR/WDATA/ACK/RDATA : data memory handshake
//   RETIRE                   : one-cycle pulse per completed instruction
//   HALTED, ERROR            : sticky status (self-loop halt / illegal insn)
//   RESULT                   : mirror of register RESULT_REG
// Optional feature: define CORE_SEQ_INSTRET_EN to add a 64-bit INSTRET
// retired-instruction counter output.
module core_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter int              NREG       = NREG_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     SP_INIT    = 500,
  parameter int unsigned     RESULT_REG = 14,
  localparam int             RW         = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [31:0]     IMEM_RDATA,
  output logic [31:0]     INSTRUCTION,
  input  logic [RW-1:0]   DEC_RS1,
  input  logic [RW-1:0]   DEC_RS2,
  input  logic [RW-1:0]   DEC_RD,
  input  logic            DEC_WB_EN,
  input  logic            DEC_LOAD,
  input  logic            DEC_STORE,
  input  logic            DEC_ILLEGAL,
  output logic [XLEN-1:0] RS1_VAL,
  output logic [XLEN-1:0] RS2_VAL,
  output logic [XLEN-1:0] PC_OUT,
  input  logic [XLEN-1:0] EXE_RESULT,
  input  logic [XLEN-1:0] EXE_NEXT_PC,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [XLEN-1:0] DMEM_WDATA,
  input  logic            DMEM_ACK,
  input  logic [XLEN-1:0] DMEM_RDATA,
  output logic            RETIRE,
  output logic            HALTED,
  output logic            ERROR,
  output logic [XLEN-1:0] RESULT
`ifdef CORE_SEQ_INSTRET_EN
  ,
  output logic [63:0]     INSTRET
`endif
);

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_next_pc;
  logic [XLEN-1:0] r_mem_data;
  logic            r_is_load;
  logic            r_imem_req;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic            r_retire;
  logic            r_halted;
  logic            r_error;

  logic            w_rf_we;
  logic [XLEN-1:0] w_rf_wdata;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;

  assign w_rf_we    = (r_state == ST_WRITE) && DEC_WB_EN;
  assign w_rf_wdata = r_is_load ? r_mem_data : r_result;

  core_regfile #(
    .XLEN       (XLEN),
    .NREG       (NREG),
    .SP_INIT    (SP_INIT),
    .RESULT_REG (RESULT_REG)
  ) u_regfile (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_rs1_idx (DEC_RS1),
    .i_rs2_idx (DEC_RS2),
    .i_we      (w_rf_we),
    .i_rd_idx  (DEC_RD),
    .i_wdata   (w_rf_wdata),
    .o_rs1_val (w_rf_rs1),
    .o_rs2_val (w_rf_rs2),
    .o_result  (RESULT)
  );

  // Next-state decode of the sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = ST_FETCH;
      ST_FETCH:   w_state_nxt = IMEM_ACK ? ST_DECODE : ST_FETCH;
      ST_DECODE:  w_state_nxt = DEC_ILLEGAL ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: w_state_nxt = (DEC_LOAD || DEC_STORE) ? ST_MEM : ST_WRITE;
      ST_MEM:     w_state_nxt = DMEM_ACK ? ST_WRITE : ST_MEM;
      // A jump to itself is the halt idiom.
      ST_WRITE:   w_state_nxt = (r_next_pc == r_pc) ? ST_HALT : ST_FETCH;
      ST_HALT:    w_state_nxt = ST_HALT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath latches and registered handshake/status outputs.
  // Request and retire flags are derived from the next state so they are
  // high exactly while the sequencer sits in FETCH / MEM / WRITE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_result   <= '0;
      r_next_pc  <= '0;
      r_mem_data <= '0;
      r_is_load  <= 1'b0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_retire   <= 1'b0;
      r_halted   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_imem_req <= (w_state_nxt == ST_FETCH);
      r_dmem_req <= (w_state_nxt == ST_MEM);
      r_retire   <= (w_state_nxt == ST_WRITE);
      case (r_state)
        ST_FETCH: begin
          if (IMEM_ACK) begin
            r_instr <= IMEM_RDATA;
          end
        end
        ST_DECODE: begin
          if (DEC_ILLEGAL) begin
            r_error <= 1'b1;
          end else begin
            r_rs1_val <= w_rf_rs1;
            r_rs2_val <= w_rf_rs2;
          end
        end
        ST_EXECUTE: begin
          r_result  <= EXE_RESULT;
          r_next_pc <= EXE_NEXT_PC;
          r_is_load <= DEC_LOAD;
          // Only a store heading into MEM raises WE; anything else clears it.
          r_dmem_we <= DEC_STORE;
        end
        ST_MEM: begin
          if (DMEM_ACK) begin
            r_dmem_we <= 1'b0;
            if (r_is_load) begin
              r_mem_data <= DMEM_RDATA;
            end
          end
        end
        ST_WRITE: begin
          r_pc <= r_next_pc;
          if (r_next_pc == r_pc) begin
            r_halted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign IMEM_REQ    = r_imem_req;
  assign IMEM_ADDR   = r_pc;
  assign INSTRUCTION = r_instr;
  assign RS1_VAL     = r_rs1_val;
  assign RS2_VAL     = r_rs2_val;
  assign PC_OUT      = r_pc;
  assign DMEM_REQ    = r_dmem_req;
  assign DMEM_WE     = r_dmem_we;
  assign DMEM_ADDR   = r_result;
  assign DMEM_WDATA  = r_rs2_val;
  assign RETIRE      = r_retire;
  assign HALTED      = r_halted;
  assign ERROR       = r_error;

`ifdef CORE_SEQ_INSTRET_EN
  logic [63:0] r_instret;

  // Retired-instruction counter; wraps naturally at 2^64.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instret <= 64'd0;
    end else if (r_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign INSTRET = r_instret;
`endif

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multicycle instruction sequencer and register file for the RISC-V core: owns the PC, the architectural register file and the FETCH/DECODE/EXECUTE/MEM/WRITE state machine. It sits between external instruction/data memories (valid/ack handshakes) and the combinational decoder and executer, replacing the fixed four-state loop and internal instruction array with parametrised width, register count, reset vector and a load/store memory stage with wait states.

## Interface
- XLEN, 32, data/address width
- NREG, 32, architectural registers; index width RW = $clog2(NREG)
- RESET_PC, 0, PC after reset (byte address)
- SP_INIT, 500, reset value of x2
- RESULT_REG, 14, register mirrored on RESULT
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- IMEM_REQ  out  1  instruction fetch request, held until IMEM_ACK
- IMEM_ADDR  out  XLEN  fetch byte address (= PC)
- IMEM_ACK  in  1  fetch complete, IMEM_RDATA valid this cycle
- IMEM_RDATA  in  32  instruction word
- INSTRUCTION  out  32  latched instruction to decoder
- DEC_RS1, DEC_RS2, DEC_RD  in  RW each  register indices from decoder
- DEC_WB_EN, DEC_LOAD, DEC_STORE, DEC_ILLEGAL  in  1 each  decoder flags
- RS1_VAL, RS2_VAL  out  XLEN  latched operands to executer
- PC_OUT  out  XLEN  current PC to executer
- EXE_RESULT  in  XLEN  ALU result / memory address
- EXE_NEXT_PC  in  XLEN  next PC
- DMEM_REQ  out  1  data request, held until DMEM_ACK
- DMEM_WE  out  1  1 = store
- DMEM_ADDR, DMEM_WDATA  out  XLEN  address (= latched EXE_RESULT), store data (= RS2_VAL)
- DMEM_ACK  in  1  data complete; DMEM_RDATA valid this cycle for loads
- DMEM_RDATA  in  XLEN  load data
- RETIRE  out  1  one-cycle pulse per completed instruction
- HALTED, ERROR  out  1 each  sticky status
- RESULT  out  XLEN  register_file[RESULT_REG]

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITE, HALT.
- IDLE: entered on reset, one cycle, no requests, ACKs ignored; -> FETCH.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC; on IMEM_ACK latch IMEM_RDATA into INSTRUCTION, -> DECODE; else stay.
- DECODE: DEC_ILLEGAL -> HALT with ERROR=1, no writeback, no RETIRE; else RS1_VAL/RS2_VAL <= regfile[DEC_RS1/RS2], -> EXECUTE.
- EXECUTE: latch EXE_RESULT and EXE_NEXT_PC; DEC_LOAD or DEC_STORE -> MEM, else -> WRITE.
- MEM: DMEM_REQ=1, DMEM_WE=DEC_STORE; on DMEM_ACK latch DMEM_RDATA for loads, -> WRITE.
- WRITE: if DEC_WB_EN and DEC_RD!=0, regfile[DEC_RD] <= load ? mem data : result; PC <= next PC; RETIRE=1; if next PC == PC -> HALT (HALTED=1), else -> FETCH.
- HALT: terminal until RST; no requests.
- x0 reads 0 always, writes discarded. Indices >= NREG read 0 and are not written.
- PC arithmetic modulo 2^XLEN; no alignment check.

## Timing
- Zero-wait ACK (same cycle as REQ): non-memory instruction 4 cycles, load/store 5; each wait cycle adds one.
- REQ, ADDR, WE, WDATA stable while REQ high; REQ drops the cycle after ACK.
- Decoder/executer inputs sampled only in DECODE/EXECUTE/WRITE; INSTRUCTION stable from DECODE until next ACK.
- RST mid-request: REQ low next cycle; any later ACK lands in IDLE and is ignored.
- Reset values: state IDLE, PC=RESET_PC, regs 0 except x2=SP_INIT, INSTRUCTION/RS*_VAL 0, all REQ/WE/RETIRE/HALTED/ERROR 0.
- Write in WRITE visible to RESULT and DECODE reads from the next cycle.

## Configuration
- CORE_SEQ_INSTRET_EN defined: adds output INSTRET (64 bits), reset 0, +1 on each RETIRE, wraps at 2^64.
- Undefined: port absent, no counter logic.

## Structure
- Package core_pkg: state enum, XLEN/NREG defaults, halt encoding constant (jal x0,0 = 0x0000006F, for benches).
- One sub-module core_regfile (NREG x XLEN, two read ports, one write port, x0 hardwired, SP_INIT/RST init).

## Test plan
- Reset then addi x14,x0,7 with zero-wait memories -> FETCH..WRITE 4 cycles, RESULT=7, RETIRE one pulse, PC=4.
- IMEM_ACK delayed 3 cycles -> IMEM_REQ high 4 cycles, address constant, instruction 7 cycles total.
- sw then lw via DMEM with 2 wait cycles -> DMEM_WE 1 then 0, load writes stored value to rd, 7-cycle instructions.
- Write to x0 -> x0 reads 0 afterwards; x2 reads 500 after reset.
- 0x0000006F at PC=8 -> HALTED=1 after its WRITE, no further IMEM_REQ; DEC_ILLEGAL -> ERROR=1, no RETIRE.
- RST asserted while IMEM_REQ waiting, ACK arriving 1 cycle later -> ignored, fetch restarts at RESET_PC.
